seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative radix-2 restoring integer divider, one quotient bit per clock; the inverse operation of the team's Booth multiplier datapath.
- Accepts a dividend/divisor pair on a start strobe and returns quotient and remainder after a fixed latency.
- Signals completion with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit, sharing its operand-register conventions.

Parameters:
- N, 32, operand width in bits; quotient and remainder are also N bits.

Ports:
- clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start strobe; sampled only in IDLE.
- i_dividend  in  N  dividend, captured when start is accepted.
- i_divisor  in  N  divisor, captured when start is accepted.
- o_busy  out  1  high from the cycle after start is accepted until the done cycle (exclusive).
- o_done  out  1  one-cycle pulse; results valid in this cycle and held until the next accepted start.
- o_quotient  out  N  quotient.
- o_remainder  out  N  remainder.
- o_div_by_zero  out  1  set with o_done when the divisor was 0; held with results.

Behaviour:
- Reset: state IDLE; o_busy=0, o_done=0, o_quotient=0, o_remainder=0, o_div_by_zero=0; iteration counter=0.
- Reset mid-operation: aborts immediately, clears all outputs, no done pulse.
- States: IDLE, ITER, FIX.
  - IDLE: when i_start=1, capture operands into the working registers.
    - Divisor==0: go to FIX with dz flag set.
    - Otherwise: go to ITER with count=0.
  - ITER: one restoring step per cycle.
    - {R,Q} shift left 1.
    - trial = R - D, computed N+1 bits wide.
    - If trial is non-negative: R=trial[N-1:0] and Q[0]=1; else Q[0]=0.
    - count increments each step; after step N (count==N-1), go to FIX.
  - FIX: apply sign correction (optional feature), register outputs, pulse o_done in the following cycle, return to IDLE.
- Latency: start accepted at the edge ending cycle T.
  - ITER occupies cycles T+1..T+N; FIX is cycle T+N+1.
  - o_done=1 in cycle T+N+2.
  - Divide by zero: o_done=1 in cycle T+2.
- Divide by zero results: quotient all ones, remainder = original dividend, o_div_by_zero=1.
- Handshake:
  - i_start while busy is ignored.
  - i_start in the o_done cycle is accepted, since the FSM is already in IDLE; this gives back-to-back operation.
  - o_done never asserts without a prior accepted start.
- Outputs are stable between o_done and the next o_done. They are not cleared on a new start.
- Operand inputs are don't-care except in the cycle start is accepted.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - IDLE captures the absolute values plus sign bits sd=dividend[N-1] and sq=sd^divisor[N-1].
  - FIX negates the quotient if sq, and negates the remainder if sd.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case MIN/-1: quotient = MIN (0x80000000 for N=32), remainder 0, no flag.
  - Divide by zero: quotient all ones (-1), remainder = dividend.
- Undefined: unsigned only; no sign logic; FIX only registers results.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, ITER, FIX).
  - default width constant DIV_N=32.
  - counter width as $clog2(DIV_N).
- Sub-module div_step:
  - Combinational single restoring step.
  - Inputs: R, Q, D. Outputs: next R, next Q.
  - Instantiated once in the ITER datapath.

Test Plan:
- Unsigned 100/7, start at T -> o_done at T+34 (N=32), q=14, r=2, o_busy high T+1..T+33, dz=0.
- 55/0 -> o_done at T+2, q=0xFFFFFFFF, r=55, o_div_by_zero=1; next valid divide clears the flag.
- Signed (SEQ_DIVIDER_SIGNED_EN): -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); 7/-2 -> q=-3, r=1; 0x80000000/-1 -> q=0x80000000, r=0.
- Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0; 3/10 -> q=0, r=3.
- i_start pulsed with new operands during ITER -> ignored, first result unchanged. i_start asserted in the o_done cycle -> second op completes exactly N+2 cycles later.
- i_rst asserted at T+10 of an op -> next cycle all outputs 0, o_busy=0, no o_done ever for that op; a fresh start after reset gives the correct result.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   state_t : divider FSM states (IDLE, ITER, FIX)
//   DIV_N   : default operand width
//   DIV_CW  : iteration counter width for the default operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIV_N  = 32;
    localparam int DIV_CW = $clog2(DIV_N);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   r      : partial remainder (always < d on entry)
//   q      : dividend/quotient shift register
//   d      : divisor
//   r_nxt  : partial remainder after the step
//   q_nxt  : shift register after the step, new quotient bit in [0]
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N-1:0] r_nxt,
    output logic [N-1:0] q_nxt
);

    logic [N:0] rs;     // {R,Q} shifted left: remainder gains the next dividend bit
    logic [N:0] trial;
    logic       ge;

    always_comb begin
        rs    = {r, q[N-1]};
        trial = rs - {1'b0, d};
        // rs can reach 2^N (R < D, so 2R+1 < 2D); when its top bit is set the
        // subtraction always succeeds even though trial[N] alone is ambiguous.
        ge    = rs[N] | ~trial[N];
        r_nxt = ge ? trial[N-1:0] : rs[N-1:0];
        q_nxt = {q[N-2:0], ge};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring integer divider, one quotient bit
// per clock. Result appears N+2 cycles after the accepted start (2 cycles for
// a zero divisor) with a one-cycle o_done pulse; results hold until the next
// completed operation.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   : two's complement operands, quotient truncates toward zero,
//               remainder takes the dividend's sign (MIN/-1 gives MIN, rem 0)
//   undefined : unsigned operands only
//
// Ports:
//   clk            clock, rising edge
//   i_rst          synchronous active-high reset, aborts any operation
//   i_start        start strobe, only honoured in IDLE
//   i_dividend     dividend, captured with the accepted start
//   i_divisor      divisor, captured with the accepted start
//   o_busy         high while an operation is in flight (ITER/FIX)
//   o_done         one-cycle completion pulse
//   o_quotient     quotient (all ones on divide by zero)
//   o_remainder    remainder (dividend on divide by zero)
//   o_div_by_zero  divisor was zero for the last completed operation
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N   // N >= 2
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int CW = $clog2(N);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  r_q, q_q, d_q;
    logic          dz_q;
    logic [N-1:0]  r_step, q_step;
    logic [N-1:0]  dvd_mag, dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic          sd_q;   // dividend sign -> remainder sign
    logic          sq_q;   // quotient sign
`endif

    // Magnitudes fed into the unsigned core. MIN maps onto itself, which is
    // the correct unsigned magnitude 2^(N-1).
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_mag = i_dividend[N-1] ? -i_dividend : i_dividend;
        dvs_mag = i_divisor[N-1]  ? -i_divisor  : i_divisor;
`else
        dvd_mag = i_dividend;
        dvs_mag = i_divisor;
`endif
    end

    div_step #(.N(N)) u_step (
        .r     (r_q),
        .q     (q_q),
        .d     (d_q),
        .r_nxt (r_step),
        .q_nxt (q_step)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = (i_divisor == '0) ? FIX : ITER;
            ITER: if (cnt == CW'(N-1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt           <= '0;
            r_q           <= '0;
            q_q           <= '0;
            d_q           <= '0;
            dz_q          <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sd_q          <= 1'b0;
            sq_q          <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cnt <= '0;
                        d_q <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        sd_q <= i_dividend[N-1];
                        sq_q <= i_dividend[N-1] ^ i_divisor[N-1];
`endif
                        if (i_divisor == '0) begin
                            // Final results are preloaded so FIX just forwards them.
                            dz_q <= 1'b1;
                            q_q  <= '1;
                            r_q  <= i_dividend;
                        end else begin
                            dz_q <= 1'b0;
                            q_q  <= dvd_mag;
                            r_q  <= '0;
                        end
                    end
                end
                ITER: begin
                    r_q <= r_step;
                    q_q <= q_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    o_quotient  <= (sq_q && !dz_q) ? -q_q : q_q;
                    o_remainder <= (sd_q && !dz_q) ? -r_q : r_q;
`else
                    o_quotient  <= q_q;
                    o_remainder <= r_q;
`endif
                    o_div_by_zero <= dz_q;
                    o_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [N-1:0] i_dividend, i_divisor;
    logic         o_busy, o_done, o_div_by_zero;
    logic [N-1:0] o_quotient, o_remainder;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference straight from the division rules.
    function automatic void model_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                      output logic [N-1:0] q, output logic [N-1:0] r,
                                      output logic dz);
        dz = 1'b0;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        else if (a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
            q = a; r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    // Transaction-level model: latency countdown plus held result.
    int           m_rem = 0;
    logic         m_done = 1'b0, m_dz = 1'b0, p_dz;
    logic [N-1:0] m_q = '0, m_r = '0, p_q, p_r;

    always @(posedge clk) begin
        if (i_rst) begin
            m_rem = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = p_dz;
                end
            end else if (i_start) begin
                model_div(i_dividend, i_divisor, p_q, p_r, p_dz);
                m_rem = p_dz ? 1 : N + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", N'(o_busy), N'(m_rem > 0));
            chk("done", N'(o_done), N'(m_done));
            chk("quotient", o_quotient, m_q);
            chk("remainder", o_remainder, m_r);
            chk("div_by_zero", N'(o_div_by_zero), N'(m_dz));
        end
    end

    // Called at a negedge: drives start this cycle, waits for o_done.
    // glitch > 0 pulses i_start with junk operands that many cycles in.
    task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                          input int elat, input int glitch);
        int lat;
        i_start = 1'b1; i_dividend = a; i_divisor = b;
        @(negedge clk);
        i_start = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
        lat = 1;
        while (!o_done && lat < 100) begin
            i_start = (lat == glitch);
            @(negedge clk);
            i_start = 1'b0;
            lat++;
        end
        chk({nm, " latency"}, N'(lat), N'(elat));
        chk({nm, " q"}, o_quotient, eq);
        chk({nm, " r"}, o_remainder, er);
        chk({nm, " dz"}, N'(o_div_by_zero), N'(edz));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] tq, tr;
        logic         tdz;
        int           seen;

        // Pin the reference model on hand-computed cases.
        model_div(32'd100, 32'd7, tq, tr, tdz);
        chk("model 100/7 q", tq, 32'd14);
        chk("model 100/7 r", tr, 32'd2);
        model_div(32'd55, 32'd0, tq, tr, tdz);
        chk("model 55/0 q", tq, 32'hFFFF_FFFF);
        chk("model 55/0 dz", N'(tdz), 32'd1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        model_div(32'hFFFF_FFF9, 32'd2, tq, tr, tdz);
        chk("model -7/2 q", tq, 32'hFFFF_FFFD);
        chk("model -7/2 r", tr, 32'hFFFF_FFFF);
`endif

        i_rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
        idle(2);
        chk("reset busy", N'(o_busy), '0);
        chk("reset done", N'(o_done), '0);
        chk("reset q", o_quotient, '0);
        chk("reset r", o_remainder, '0);
        chk("reset dz", N'(o_div_by_zero), '0);
        chk_en = 1'b1;
        i_rst = 1'b0;
        idle(2);

        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, N + 2, 0);
        idle(3);
        run_op("55/0", 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 2, 0);
        idle(1);
        run_op("20/4", 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, N + 2, 0);
        idle(2);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, N + 2, 0);
        idle(2);
        run_op("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, N + 2, 0);
        idle(2);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, N + 2, 0);
        idle(1);
        run_op("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, N + 2, 0);
        idle(1);
        run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, N + 2, 0);
        idle(1);
        run_op("-9/0", 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 2, 0);
        idle(1);
`else
        run_op("max/msb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, N + 2, 0);
        idle(1);
`endif
        // Start pulsed mid-iteration must be ignored.
        run_op("glitch 1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, N + 2, 5);
        idle(2);
        // Back-to-back: second start lands in the done cycle.
        run_op("b2b 12345/100", 32'd12345, 32'd100, 32'd123, 32'd45, 1'b0, N + 2, 0);
        run_op("b2b 7/7", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, N + 2, 0);
        idle(2);

        // Reset in cycle T+10 of an operation.
        i_start = 1'b1; i_dividend = 32'd999; i_divisor = 32'd9;
        @(negedge clk);
        i_start = 1'b0;
        idle(9);
        i_rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", N'(o_busy), '0);
        chk("midrst done", N'(o_done), '0);
        chk("midrst q", o_quotient, '0);
        chk("midrst r", o_remainder, '0);
        i_rst = 1'b0;
        seen = 0;
        repeat (N + 8) begin
            @(negedge clk);
            if (o_done) seen++;
        end
        chk("midrst no done", N'(seen), '0);
        run_op("post-rst 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, N + 2, 0);
        idle(3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
